ram_march_bist: RTL

RAM_MARCH_BIST -- requirements
Module: ram_march_bist

---
 rtl/ram_march_bist.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ram_march_bist.sv
// ram_march_bist
// March C- built-in self test for a single-port synchronous RAM, using the
// all-zeros (Z) and all-ones (O) data backgrounds:
//   M0 up(wZ); M1 up(rZ,wO); M2 up(rO,wZ); M3 down(rZ,wO); M4 down(rO,wZ); M5 up(rZ)
// A write takes one cycle (WRITE). A read takes two cycles on one address:
// ISSUE (read command) and CHECK (out_en high, data_out compared at the end).
// A full run therefore lasts 15*mem_depth cycles.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset (forces IDLE, all outputs 0)
//   start      one-cycle test request, honoured only in IDLE or DONE
//   cs         RAM chip select
//   wr_rd      RAM direction, 1 = write, 0 = read
//   out_en     RAM output enable
//   address    RAM word address
//   data_in    RAM write data
//   data_out   RAM read data
//   busy       high while the march is running
//   done       high while in DONE
//   fail       sticky mismatch flag
//   fail_addr  address of the first mismatch
//   err_cnt    saturating mismatch count
//
// Build option
//   BIST_ERR_CNT_EN  when defined, err_cnt counts mismatches (saturating at
//                    255, cleared at test start); otherwise err_cnt is tied 0.

module ram_march_bist #(
    parameter int data_width = 8,
    parameter int addr_size  = 4,
    parameter int mem_depth  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  cs,
    output logic                  wr_rd,
    output logic                  out_en,
    output logic [addr_size-1:0]  address,
    output logic [data_width-1:0] data_in,
    input  logic [data_width-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [addr_size-1:0]  fail_addr,
    output logic [7:0]            err_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] PH_ISSUE = 2'd0;
    localparam logic [1:0] PH_CHECK = 2'd1;
    localparam logic [1:0] PH_WRITE = 2'd2;

    localparam logic [2:0] EL_M0 = 3'd0;
    localparam logic [2:0] EL_M1 = 3'd1;
    localparam logic [2:0] EL_M2 = 3'd2;
    localparam logic [2:0] EL_M3 = 3'd3;
    localparam logic [2:0] EL_M4 = 3'd4;
    localparam logic [2:0] EL_M5 = 3'd5;

    localparam logic [addr_size-1:0]  ADDR_FIRST = {addr_size{1'b0}};
    localparam logic [addr_size-1:0]  ADDR_LAST  = addr_size'(mem_depth - 1);
    localparam logic [addr_size-1:0]  ADDR_ONE   = addr_size'(1);
    localparam logic [data_width-1:0] BG_ZERO    = {data_width{1'b0}};
    localparam logic [data_width-1:0] BG_ONE     = {data_width{1'b1}};

    // Elements M3 and M4 walk the address space downwards.
    function automatic logic el_down(input logic [2:0] el);
        return (el == EL_M3) || (el == EL_M4);
    endfunction

    // Background written by each element.
    function automatic logic [data_width-1:0] write_bg(input logic [2:0] el);
        logic [data_width-1:0] bg;
        case (el)
            EL_M1, EL_M3: bg = BG_ONE;
            default:      bg = BG_ZERO;
        endcase
        return bg;
    endfunction

    // Background each element expects to read back.
    function automatic logic [data_width-1:0] read_bg(input logic [2:0] el);
        logic [data_width-1:0] bg;
        case (el)
            EL_M2, EL_M4: bg = BG_ONE;
            default:      bg = BG_ZERO;
        endcase
        return bg;
    endfunction

    logic [1:0]           state_r, state_s;
    logic [1:0]           phase_r, phase_s;
    logic [2:0]           elem_r, elem_s;
    logic [addr_size-1:0] addr_r, addr_s;

    logic                 at_end_s;
    logic [addr_size-1:0] addr_step_s;
    logic [2:0]           elem_inc_s;
    logic                 run_s;
    logic                 start_acc_s;
    logic                 mismatch_s;

    assign at_end_s    = el_down(elem_r) ? (addr_r == ADDR_FIRST) : (addr_r == ADDR_LAST);
    assign addr_step_s = el_down(elem_r) ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
    assign elem_inc_s  = elem_r + 3'd1;
    assign run_s       = (state_s == ST_RUN);
    // A start is only honoured while not running, so busy masks it.
    assign start_acc_s = start && (state_r != ST_RUN);
    assign mismatch_s  = (state_r == ST_RUN) && (phase_r == PH_CHECK) &&
                         (data_out != read_bg(elem_r));

    // March sequencer: next state, phase, element and address.
    always_comb begin
        state_s = state_r;
        phase_s = phase_r;
        elem_s  = elem_r;
        addr_s  = addr_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_RUN;
                    phase_s = PH_WRITE;
                    elem_s  = EL_M0;
                    addr_s  = ADDR_FIRST;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                case (phase_r)
                    PH_ISSUE: begin
                        phase_s = PH_CHECK;
                    end
                    PH_CHECK: begin
                        // M5 is read-only, so its CHECK closes the address.
                        if (elem_r == EL_M5) begin
                            if (at_end_s) begin
                                state_s = ST_DONE;
                                phase_s = PH_ISSUE;
                                elem_s  = EL_M0;
                                addr_s  = ADDR_FIRST;
                            end else begin
                                phase_s = PH_ISSUE;
                                addr_s  = addr_step_s;
                            end
                        end else begin
                            phase_s = PH_WRITE;
                        end
                    end
                    PH_WRITE: begin
                        if (at_end_s) begin
                            elem_s  = elem_inc_s;
                            phase_s = PH_ISSUE;
                            addr_s  = el_down(elem_inc_s) ? ADDR_LAST : ADDR_FIRST;
                        end else begin
                            addr_s  = addr_step_s;
                            // M0 is write-only; every other element reads first.
                            phase_s = (elem_r == EL_M0) ? PH_WRITE : PH_ISSUE;
                        end
                    end
                    default: begin
                        state_s = ST_IDLE;
                        phase_s = PH_ISSUE;
                        elem_s  = EL_M0;
                        addr_s  = ADDR_FIRST;
                    end
                endcase
            end
            default: begin
                state_s = ST_IDLE;
                phase_s = PH_ISSUE;
                elem_s  = EL_M0;
                addr_s  = ADDR_FIRST;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            phase_r <= PH_ISSUE;
            elem_r  <= EL_M0;
            addr_r  <= ADDR_FIRST;
        end else begin
            state_r <= state_s;
            phase_r <= phase_s;
            elem_r  <= elem_s;
            addr_r  <= addr_s;
        end
    end

    // Outputs registered from the next state so they line up with state_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs      <= 1'b0;
            wr_rd   <= 1'b0;
            out_en  <= 1'b0;
            address <= ADDR_FIRST;
            data_in <= BG_ZERO;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            cs      <= run_s;
            wr_rd   <= run_s && (phase_s == PH_WRITE);
            out_en  <= run_s && (phase_s == PH_CHECK);
            address <= run_s ? addr_s : ADDR_FIRST;
            data_in <= (run_s && (phase_s == PH_WRITE)) ? write_bg(elem_s) : BG_ZERO;
            busy    <= run_s;
            done    <= (state_s == ST_DONE);
        end
    end

    // Sticky fail flag; only the first mismatch loads fail_addr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail      <= 1'b0;
            fail_addr <= ADDR_FIRST;
        end else if (start_acc_s) begin
            fail      <= 1'b0;
            fail_addr <= ADDR_FIRST;
        end else if (mismatch_s && !fail) begin
            fail      <= 1'b1;
            fail_addr <= addr_r;
        end else begin
            fail      <= fail;
            fail_addr <= fail_addr;
        end
    end

`ifdef BIST_ERR_CNT_EN
    // Saturating mismatch counter, cleared when a test starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (start_acc_s) begin
            err_cnt <= 8'd0;
        end else if (mismatch_s && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end else begin
            err_cnt <= err_cnt;
        end
    end
`else
    assign err_cnt = 8'd0;
`endif

endmodule
